nios2_keys: RTL and testbench
=============================

NIOS2_KEYS -- requirements
Module: nios2_keys

Interface
REQ-001 Parameter WIDTH, default 4: number of key input bits, 1..32.
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000: consecutive stable cycles required to accept a key change, >=1.
REQ-003 clk  input  1: single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1: reset, synchronous and active-low.
REQ-005 address  input  2: Avalon-MM slave word address.
REQ-006 chipselect  input  1: slave select.
REQ-007 write_n  input  1: active-low write strobe.
REQ-008 writedata  input  32: write data.
REQ-009 in_port  input  WIDTH: raw asynchronous key levels, active-low (1 = released).
REQ-010 readdata  output  32: read data, combinational from address, zero wait states.
REQ-011 irq  output  1: level interrupt request, active-high.

Function
REQ-012 Each in_port bit SHALL pass through a two-flop synchronizer (sync1, sync2) before any other use.
REQ-013 Each bit SHALL have an independent debounce counter of width ceil(log2(DEBOUNCE_CYCLES+1)), saturating, never wrapping.
REQ-014 Counter clears on every edge where sync2 equals the debounced value db; otherwise it increments.
REQ-015 On the edge where the increment would reach DEBOUNCE_CYCLES, db takes sync2 and the counter clears.
REQ-016 Latency: an in_port change stable from edge E0 SHALL appear in db after edge E0+DEBOUNCE_CYCLES+1; any bounce before then restarts the count.
REQ-017 edge_capture[i] SHALL set on the edge where db[i] changes 1->0 (key press); releases (0->1) set nothing.
REQ-018 irq_mask is a WIDTH-bit read/write register; irq = OR of (edge_capture AND irq_mask), combinational from registers.
REQ-019 Register map:
  - addr 0: db (read-only; writes ignored)
  - addr 1: reads 0; writes ignored
  - addr 2: irq_mask (read/write)
  - addr 3: edge_capture (read; write-1-to-clear per bit)
REQ-020 A write occurs on an edge with chipselect=1 and write_n=0; only writedata[WIDTH-1:0] is used.
REQ-021 readdata bits 31..WIDTH SHALL read 0; reads have no side effects.
REQ-022 If a press sets edge_capture[i] on the same edge that a write-1-to-clear targets bit i, the bit SHALL end set (set wins).
REQ-023 Clearing edge_capture bits whose keys are still held SHALL NOT re-set them; only a new 1->0 db transition sets them.
REQ-024 Simultaneous presses on several bits SHALL each set their own capture bit on their own qualifying edge.

Reset
REQ-025 With reset_n=0 at an edge: sync1, sync2 and db set to all ones; counters, edge_capture and irq_mask clear to 0.
REQ-026 After reset irq=0 and readdata at addr 0 = {zeros, WIDTH ones}; reset mid-debounce discards the partial count.
REQ-027 Releasing reset with any in_port bit held low SHALL register that press as a normal 1->0 transition after DEBOUNCE_CYCLES+2 edges.

Verification (WIDTH=4, DEBOUNCE_CYCLES=4)
REQ-028 Clean press: in_port 1111->1110 at edge E0 -> addr0 reads 0x0000000E after edge E0+5, not before; addr3 reads 0x1 at the same time; irq stays 0 while mask is 0.
REQ-029 Bounce: bit 1 toggles low 3 cycles, high 1, then low steady -> db[1] falls exactly 5 edges after the last toggle; edge_capture[1] set once.
REQ-030 IRQ: write 0x2 to addr 2, press bit 1 -> irq=1 after the capture edge; write 0x2 to addr 3 -> irq=0 next cycle; key still held -> irq stays 0.
REQ-031 Set/clear race: write 0x4 to addr 3 on the edge bit 2's db falls -> addr3 bit 2 reads 1.
REQ-032 Reset mid-count: bit 0 low for 3 stable cycles, reset_n=0 one edge, release -> db[0] falls only after a full fresh 6-edge latency.
REQ-033 Bus: write 0xFFFFFFFF to addr 0 and addr 1 -> no state change; addr 1 reads 0; addr 2 then reads 0x0000000F after writing 0xFFFFFFFF to addr 2.

Source files
------------

// File: rtl/nios2_keys.sv
`default_nettype none
// ============================================================================
//  Module      : nios2_keys
//  Description : Avalon-MM key/button port. Synchronizes and debounces
//                active-low key inputs, latches key presses in an
//                edge-capture register and raises a maskable level IRQ.
//  Revision    : 1.0 - initial release
// ============================================================================
module nios2_keys #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    input  logic [WIDTH-1:0]  in_port,
    output logic [31:0]       readdata,
    output logic              irq
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    // Count value at which the next increment would reach DEBOUNCE_CYCLES.
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] db;
    logic [WIDTH-1:0] db_nxt;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] ec_clear;
    logic [CW-1:0]    cnt     [WIDTH];
    logic [CW-1:0]    cnt_nxt [WIDTH];
    logic             wr_en;
    logic             unused_bits;

    assign wr_en       = chipselect & ~write_n;
    // Only the low WIDTH bits of writedata carry meaning.
    assign unused_bits = &{1'b0, writedata};

    // Per-bit debounce: count while sync2 disagrees with db, accept on the
    // edge the count would reach DEBOUNCE_CYCLES; agreement restarts it.
    always_comb begin
        db_nxt = db;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt[i] = '0;
            if (sync2[i] != db[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    db_nxt[i] = sync2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    // A press is a 1->0 transition of the debounced level.
    assign fall     = db & ~db_nxt;
    assign ec_clear = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    // Synchronizer, debounced level and debounce counters.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1 <= '1;
            sync2 <= '1;
            db    <= '1;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
            db    <= db_nxt;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

    // Bus-visible registers; a press on the same edge as its clear wins.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            edge_capture <= '0;
            irq_mask     <= '0;
        end else begin
            edge_capture <= (edge_capture & ~ec_clear) | fall;
            if (wr_en && address == 2'd2) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
        end
    end

    // Zero-wait-state read mux, upper bits always zero.
    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata[WIDTH-1:0] = db;
            2'd2:    readdata[WIDTH-1:0] = irq_mask;
            2'd3:    readdata[WIDTH-1:0] = edge_capture;
            default: readdata = '0;
        endcase
    end

    assign irq = |(edge_capture & irq_mask);

endmodule
`default_nettype wire

// File: tb/tb_nios2_keys.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nios2_keys
//  Description : Self-checking bench for nios2_keys (WIDTH=4, DEBOUNCE=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nios2_keys;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int nvec;
    int nerr;

    typedef struct {
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } bus_vec_t;

    bus_vec_t vecs [10];

    nios2_keys #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic rd_check(input string name, input logic [1:0] a, input logic [31:0] exp);
        address = a;
        #1;
        check(name, readdata, exp);
    endtask

    task automatic irq_check(input string name, input logic exp);
        #1;
        check(name, {31'b0, irq}, {31'b0, exp});
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    initial begin
        nvec       = 0;
        nerr       = 0;
        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 4'hF;

        vecs[0] = '{1'b0, 2'd0, 32'h0,        32'h0000000F, 1'b0};
        vecs[1] = '{1'b0, 2'd1, 32'h0,        32'h00000000, 1'b0};
        vecs[2] = '{1'b0, 2'd2, 32'h0,        32'h00000000, 1'b0};
        vecs[3] = '{1'b0, 2'd3, 32'h0,        32'h00000000, 1'b0};
        vecs[4] = '{1'b1, 2'd0, 32'hFFFFFFFF, 32'h0000000F, 1'b0};
        vecs[5] = '{1'b1, 2'd1, 32'hFFFFFFFF, 32'h00000000, 1'b0};
        vecs[6] = '{1'b0, 2'd2, 32'h0,        32'h00000000, 1'b0};
        vecs[7] = '{1'b1, 2'd2, 32'hFFFFFFFF, 32'h0000000F, 1'b0};
        vecs[8] = '{1'b1, 2'd3, 32'hFFFFFFFF, 32'h00000000, 1'b0};
        vecs[9] = '{1'b1, 2'd2, 32'h00000000, 32'h00000000, 1'b0};

        tick_n(2);
        reset_n = 1'b1;
        tick();

        // Register map / reset values
        for (int v = 0; v < 10; v++) begin
            if (vecs[v].wr) bus_write(vecs[v].addr, vecs[v].wdata);
            rd_check($sformatf("bus_vec%0d", v), vecs[v].addr, vecs[v].exp_rd);
            irq_check($sformatf("bus_vec%0d_irq", v), vecs[v].exp_irq);
        end

        // Clean press of bit 0: visible after E0+5, not before
        in_port = 4'b1110;
        for (int k = 0; k < 5; k++) begin
            tick();
            rd_check($sformatf("clean_pre%0d", k), 2'd0, 32'hF);
        end
        tick();
        rd_check("clean_db", 2'd0, 32'hE);
        rd_check("clean_ec", 2'd3, 32'h1);
        irq_check("clean_irq", 1'b0);
        in_port = 4'hF;
        tick_n(8);
        rd_check("release_db", 2'd0, 32'hF);
        rd_check("release_ec", 2'd3, 32'h1);
        bus_write(2'd3, 32'h1);
        rd_check("clear_ec", 2'd3, 32'h0);

        // Bounce on bit 1: low 3, high 1, then steady low
        in_port = 4'b1101;
        tick_n(3);
        in_port = 4'b1111;
        tick();
        in_port = 4'b1101;
        for (int k = 0; k < 5; k++) begin
            tick();
            rd_check($sformatf("bounce_pre%0d", k), 2'd0, 32'hF);
        end
        tick();
        rd_check("bounce_db", 2'd0, 32'hD);
        rd_check("bounce_ec", 2'd3, 32'h2);
        tick_n(6);
        rd_check("bounce_ec_hold", 2'd3, 32'h2);
        in_port = 4'hF;
        tick_n(8);
        bus_write(2'd3, 32'h2);
        rd_check("bounce_clear", 2'd3, 32'h0);

        // IRQ: mask bit 1, press, clear while held
        bus_write(2'd2, 32'h2);
        irq_check("irq_masked_idle", 1'b0);
        in_port = 4'b1101;
        tick_n(5);
        irq_check("irq_before_capture", 1'b0);
        tick();
        irq_check("irq_on_capture", 1'b1);
        bus_write(2'd3, 32'h2);
        irq_check("irq_after_clear", 1'b0);
        tick_n(10);
        irq_check("irq_held", 1'b0);
        rd_check("ec_held", 2'd3, 32'h0);
        in_port = 4'hF;
        tick_n(8);
        irq_check("irq_release", 1'b0);

        // Set/clear race on bit 2
        in_port = 4'b1011;
        tick_n(5);
        bus_write(2'd3, 32'h4);
        rd_check("race_db", 2'd0, 32'hB);
        rd_check("race_ec", 2'd3, 32'h4);
        in_port = 4'hF;
        tick_n(8);
        bus_write(2'd3, 32'hF);
        rd_check("race_clear", 2'd3, 32'h0);

        // Reset mid-count on bit 0
        in_port = 4'b1110;
        tick_n(3);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        rd_check("rst_db", 2'd0, 32'hF);
        rd_check("rst_mask", 2'd2, 32'h0);
        irq_check("rst_irq", 1'b0);
        for (int k = 1; k < 6; k++) begin
            tick();
            rd_check($sformatf("rst_pre%0d", k), 2'd0, 32'hF);
        end
        tick();
        rd_check("rst_db_fall", 2'd0, 32'hE);
        rd_check("rst_ec", 2'd3, 32'h1);
        in_port = 4'hF;
        tick_n(8);
        bus_write(2'd3, 32'hF);

        // Simultaneous presses on bits 0 and 3
        in_port = 4'b0110;
        tick_n(5);
        rd_check("multi_pre", 2'd3, 32'h0);
        tick();
        rd_check("multi_db", 2'd0, 32'h6);
        rd_check("multi_ec", 2'd3, 32'h9);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
